// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the ysyx_25020047 data-memory responder.
// The LFSR constants are only consumed when YSYX_25020047_DMEM_RAND_DELAY_EN is defined.
package ysyx_25020047_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] DMEM_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ysyx_25020047_lfsr8.sv
// Free-running 8-bit Galois LFSR used to add random extra latency
// (instantiated only when YSYX_25020047_DMEM_RAND_DELAY_EN is defined).
module ysyx_25020047_lfsr8
  import ysyx_25020047_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= DMEM_LFSR_SEED;
    end else if (out[0]) begin
      out <= (out >> 1) ^ DMEM_LFSR_TAPS;
    end else begin
      out <= out >> 1;
    end
  end

endmodule

// File: rtl/ysyx_25020047_dmem_resp.sv
// Data-memory responder: one read or byte-masked write at a time, fixed latency, held response.
// Define YSYX_25020047_DMEM_RAND_DELAY_EN to add 0-3 random extra wait cycles per request.
module ysyx_25020047_dmem_resp
  import ysyx_25020047_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDXW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);

  dmem_state_t     state;
  dmem_state_t     next_state;
  logic [4:0]      cnt;
  logic [4:0]      load_cnt;
  logic [32:0]     offset;
  logic            in_range;
  logic            accept;
  logic [IDXW-1:0] idx;
  logic [31:0]     mem [DEPTH];

  // A 33-bit difference makes addresses below BASE wrap to huge values, so one compare covers both bounds.
  assign offset    = {1'b0, req_addr} - {1'b0, BASE};
  assign in_range  = offset < SPAN;
  assign idx       = offset[IDXW+1:2];
  assign accept    = (state == IDLE) && req_valid;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  ysyx_25020047_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  assign load_cnt = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
  assign load_cnt = 5'(LATENCY - 1);
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (load_cnt == 5'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 5'd1) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The response is captured at acceptance, so it stays stable for the whole RESP phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt       <= load_cnt;
        rsp_err   <= !in_range;
        rsp_rdata <= (in_range && !req_wen) ? mem[idx] : 32'd0;
      end else if (state == WAIT) begin
        cnt <= cnt - 5'd1;
      end
    end
  end

  // Array is deliberately not reset; writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && in_range && req_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wmask[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_dmem_resp.sv
// Self-checking bench for ysyx_25020047_dmem_resp using a reference word model and a response scoreboard.
module tb_ysyx_25020047_dmem_resp;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          LATENCY = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  exp_t        sbQueue[$];
  logic [31:0] model [int];
  int          checkCount = 0;
  int          passCount = 0;

  ysyx_25020047_dmem_resp #(
    .DEPTH   (DEPTH),
    .BASE    (BASE),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  function automatic bit addrInRange(input logic [31:0] addr);
    longint a = longint'(addr);
    longint b = longint'(BASE);
    return (a >= b) && (a < b + 4 * DEPTH);
  endfunction

  // One full transaction: drive, update model at acceptance, wait for the response, hold, handshake.
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input int hold);
    exp_t        e;
    exp_t        got;
    int          lat;
    int          idx;
    logic [31:0] w;
    e.err   = !addrInRange(addr);
    e.rdata = 32'd0;
    idx     = int'((addr - BASE) >> 2);
    if (!e.err && !wen) e.rdata = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    checkOutput("req_ready idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    sbQueue.push_back(e);
    if (!e.err && wen) begin
      w = model.exists(idx) ? model[idx] : 32'd0;
      for (int i = 0; i < 4; i++) if (wmask[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model[idx] = w;
    end
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (lat == 1) checkOutput("req_ready busy", {31'd0, req_ready}, 32'd0);
    end while (!rsp_valid && lat < 40);
    got = sbQueue.pop_front();
    if (!rsp_valid) begin
      checkOutput("rsp timeout", 32'd0, 32'd1);
      return;
    end
`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
    checkOutput("latency range", {31'd0, (lat >= LATENCY) && (lat <= LATENCY + 3)}, 32'd1);
`else
    checkOutput("latency", lat, LATENCY);
`endif
    checkOutput("rsp_rdata", rsp_rdata, got.rdata);
    checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, got.err});
    rsp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("hold rsp_rdata", rsp_rdata, got.rdata);
      checkOutput("hold rsp_err", {31'd0, rsp_err}, {31'd0, got.err});
      checkOutput("hold req_ready", {31'd0, req_ready}, 32'd0);
      if (i == hold - 1) rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("post rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("post req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Reset lands while a write sits in WAIT: the response is dropped but the write stays committed.
  task automatic resetMidWrite(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = 4'hF;
    @(posedge clk);
    model[int'((addr - BASE) >> 2)] = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    checkOutput("rst hold rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rel req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic        wen;
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    applyStimulus(1'b0, 32'h8000_0013, 32'd0, 4'h0, 0);
    applyStimulus(1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 0);
    applyStimulus(1'b0, 32'h8000_0010, 32'd0, 4'h0, 0);
    applyStimulus(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1);
    applyStimulus(1'b0, 32'h8000_0010, 32'd0, 4'h0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, 0);
    applyStimulus(1'b1, 32'h8000_0FFC, 32'h5566_7788, 4'hF, 0);
    applyStimulus(1'b0, 32'h8000_0FFC, 32'd0, 4'h0, 0);
    applyStimulus(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0);
    applyStimulus(1'b0, 32'h8000_1000, 32'd0, 4'h0, 0);
    applyStimulus(1'b1, 32'h8000_1000, 32'hCAFE_BABE, 4'hF, 0);
    applyStimulus(1'b1, 32'h7FFF_FFFC, 32'hCAFE_BABE, 4'hF, 0);
    applyStimulus(1'b0, 32'h8000_0000, 32'd0, 4'h0, 0);
    applyStimulus(1'b0, 32'h8000_0FFC, 32'd0, 4'h0, 0);
    applyStimulus(1'b0, 32'h8000_0010, 32'd0, 4'h0, 5);

    resetMidWrite(32'h8000_0020, 32'h1234_5678);
    applyStimulus(1'b0, 32'h8000_0020, 32'd0, 4'h0, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h8000_0100 + 32'(4 * i), $urandom, 4'hF, 0);
    end
    for (int i = 0; i < 40; i++) begin
      addr = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      wen  = 1'($urandom_range(0, 2) == 0);
      applyStimulus(wen, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
